// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin arbiter that shares one UART TX byte channel between NR_REQ requesters.
// A grant is held until its owner sends CR or stays idle for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned NR_REQ  = 4,
  parameter int unsigned NR_BITS = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_REQ*NR_BITS-1:0] req_d,
  input  logic [NR_REQ-1:0]         req_dv,
  output logic [NR_REQ-1:0]         req_dr,
  output logic [NR_REQ-1:0]         grant,
  output logic                      busy,
  output logic [NR_BITS-1:0]        tx_d,
  output logic                      tx_dv,
  input  logic                      tx_dr
);

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

  localparam int unsigned      IdxW    = clog2(NR_REQ);
  localparam int unsigned      CntW    = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NR_BITS-1:0] Cr    = NR_BITS'(8'h0D);

  if (NR_BITS != 8 || NR_REQ < 2 || NR_REQ > 8) begin : g_bad_param
    $fatal(1, "uart_tx_arbiter: NR_BITS must be 8 and NR_REQ within 2..8");
  end

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              r_state;
  logic [NR_REQ-1:0]   r_grant;
  logic [IdxW-1:0]     r_gidx;
  logic [IdxW-1:0]     r_last;
  logic [CntW-1:0]     r_cnt;
  logic [NR_BITS-1:0]  r_tx_d;
  logic                r_tx_dv;

  logic [IdxW-1:0]     w_pick;
  logic [NR_REQ-1:0]   w_req_dr;
  logic                w_xfer;
  logic [NR_BITS-1:0]  w_byte;
  logic                w_timeout;
  logic                w_release;

  // Scan downwards so the closest requester after r_last is the one left in w_pick.
  always_comb begin
    int idx;
    idx    = 0;
    w_pick = r_last;
    for (int i = int'(NR_REQ); i >= 1; i--) begin
      idx = (int'(r_last) + i) % int'(NR_REQ);
      if (req_dv[idx]) w_pick = IdxW'(idx);
    end
  end

  assign w_req_dr  = (r_state == StLocked && (!r_tx_dv || tx_dr)) ? r_grant : '0;
  assign w_xfer    = |(req_dv & w_req_dr);
  assign w_byte    = req_d[r_gidx*NR_BITS +: NR_BITS];
  assign w_timeout = (TIMEOUT != 0) && !w_xfer && (r_cnt == CntLast);
  assign w_release = (w_xfer && (w_byte == Cr)) || w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IdxW'(NR_REQ - 1);
      r_cnt   <= '0;
      r_tx_d  <= '0;
      r_tx_dv <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_tx_d  <= w_byte;
        r_tx_dv <= 1'b1;
      end else if (tx_dr) begin
        r_tx_dv <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (|req_dv) begin
            r_state <= StLocked;
            r_grant <= NR_REQ'(1) << w_pick;
            r_gidx  <= w_pick;
            r_cnt   <= '0;
          end
        end
        StLocked: begin
          if (w_release) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= r_gidx;
            r_cnt   <= '0;
          end else if (w_xfer) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_dr = w_req_dr;
  assign grant  = r_grant;
  assign busy   = (r_state == StLocked);
  assign tx_d   = r_tx_d;
  assign tx_dv  = r_tx_dv;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues drive the DUT, a line-level arbitration model
// fills byte/grant scoreboards, and a monitor checks every TX byte and grant against them.
module tb_uart_tx_arbiter;
  localparam int NrReq   = 4;
  localparam int NrBits  = 8;
  localparam int Timeout = 16;
  localparam logic [7:0] Cr = 8'h0D;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NrReq*NrBits-1:0] req_d;
  logic [NrReq-1:0]        req_dv;
  logic [NrReq-1:0]        req_dr;
  logic [NrReq-1:0]        grant;
  logic                    busy;
  logic [NrBits-1:0]       tx_d;
  logic                    tx_dv;
  logic                    tx_dr;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   stall_until = 0;
  bit   rand_dr = 1'b0;

  logic [7:0] src_q[NrReq][$];  // bytes still to be offered by each requester
  logic [7:0] mdl_q[NrReq][$];  // bytes not yet placed in the expected stream
  logic [7:0] exp_q[$];
  int         exp_g_q[$];
  int         mdl_last = NrReq - 1;

  uart_tx_arbiter #(
    .NR_REQ (NrReq),
    .NR_BITS(NrBits),
    .TIMEOUT(Timeout)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_d (req_d),
    .req_dv(req_dv),
    .req_dr(req_dr),
    .grant (grant),
    .busy  (busy),
    .tx_d  (tx_d),
    .tx_dv (tx_dv),
    .tx_dr (tx_dr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic push_byte(input int k, input logic [7:0] b);
    src_q[k].push_back(b);
    mdl_q[k].push_back(b);
  endtask

  task automatic send(input int k, input string s, input bit with_cr);
    for (int i = 0; i < s.len(); i++) push_byte(k, s[i]);
    if (with_cr) push_byte(k, Cr);
  endtask

  // Line-level arbitration: whole lines go out in round-robin order starting after the last owner.
  task automatic model_flush();
    int         pick;
    logic [7:0] b;
    bit         done;
    done = 1'b0;
    while (!done) begin
      pick = -1;
      for (int i = 1; i <= NrReq; i++)
        if (pick < 0 && mdl_q[(mdl_last + i) % NrReq].size() > 0) pick = (mdl_last + i) % NrReq;
      if (pick < 0) begin
        done = 1'b1;
      end else begin
        exp_g_q.push_back(pick);
        while (mdl_q[pick].size() > 0) begin
          b = mdl_q[pick].pop_front();
          exp_q.push_back(b);
          if (b == Cr) break;
        end
        mdl_last = pick;
      end
    end
  endtask

  function automatic bit src_empty();
    for (int k = 0; k < NrReq; k++) if (src_q[k].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_grant(input logic [NrReq-1:0] g, input string name, output int at);
    at = -1;
    for (int n = 0; n < 200 && at < 0; n++) begin
      @(negedge clk);
      if (grant == g) at = cyc;
    end
    if (at < 0) bound_fail(name);
  endtask

  task automatic wait_req(input int k, input bit need_dr, input string name, output int at);
    at = -1;
    for (int n = 0; n < 200 && at < 0; n++) begin
      @(negedge clk);
      if (req_dv[k] && (!need_dr || req_dr[k])) at = cyc;
    end
    if (at < 0) bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (grant == '0) && !tx_dv && src_empty();
    end
    if (!done) bound_fail(name);
  endtask

  // Requester and sink driver: inputs change only 1ns after the rising edge.
  initial begin
    logic [NrReq-1:0] acc;
    int               low_run;
    low_run = 0;
    req_dv  = '0;
    req_d   = '0;
    tx_dr   = 1'b1;
    forever begin
      @(negedge clk);
      acc = req_dv & req_dr;
      @(posedge clk);
      #1;
      for (int k = 0; k < NrReq; k++) begin
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        req_dv[k] = (src_q[k].size() > 0);
        req_d[k*NrBits +: NrBits] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
      end
      if (cyc < stall_until) begin
        tx_dr = 1'b0;
      end else if (rand_dr && low_run < 3 && $urandom_range(0, 3) == 0) begin
        tx_dr = 1'b0;
        low_run++;
      end else begin
        tx_dr   = 1'b1;
        low_run = 0;
      end
    end
  end

  // Monitor: scoreboard compare of output bytes and grant order, plus per-cycle handshake rules.
  initial begin
    logic [NrReq-1:0] prev_g;
    logic             held;
    logic [7:0]       held_d;
    prev_g = '0;
    held   = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held   = 1'b0;
        prev_g = grant;
      end else begin
        if (held) begin
          check("hold_tx_dv", tx_dv, 1);
          check("hold_tx_d", tx_d, held_d);
        end
        held   = tx_dv && !tx_dr;
        held_d = tx_d;
        if (tx_dv && tx_dr) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got %0h expected no byte (cycle %0d)", tx_d, cyc);
          end else begin
            check("tx_byte", tx_d, exp_q.pop_front());
          end
        end
        if (grant != prev_g && grant != '0) begin
          if (exp_g_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_unexpected: got %b expected no grant (cycle %0d)", grant, cyc);
          end else begin
            check("grant_order", grant, 32'd1 << exp_g_q.pop_front());
          end
        end
        check("grant_onehot0", $onehot0(grant), 1);
        check("busy", busy, grant != '0);
        check("req_dr", req_dr, (tx_dv && !tx_dr) ? '0 : grant);
        prev_g = grant;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c;
    repeat (2) @(negedge clk);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_d", tx_d, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_req_dr", req_dr, 0);

    // Requesters 0 and 2 waiting at reset exit: 0 wins, one idle cycle, then 2.
    send(0, "X", 1'b1);
    send(2, "X", 1'b1);
    model_flush();
    @(posedge clk);
    #2 rst = 1'b0;
    wait_grant(4'b0001, "t2_grant0", a);
    wait_grant(4'b0000, "t2_release", b);
    wait_grant(4'b0100, "t2_grant2", c);
    check("t2_idle_gap", c - b, 1);
    wait_idle("t2_idle");

    // Single requester line at full rate.
    send(0, "AB", 1'b1);
    model_flush();
    wait_req(0, 1'b0, "t1_dv", a);
    wait_grant(4'b0001, "t1_grant", b);
    check("t1_grant_latency", b - a, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_rate", tx_dv, 1);
    end
    check("t1_release", grant, 0);
    wait_idle("t1_idle");

    // All four streaming one-byte lines.
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < NrReq; k++) begin
        push_byte(k, 8'($urandom_range(8'h20, 8'h7E)));
        push_byte(k, Cr);
      end
    model_flush();
    wait_idle("t3_idle");

    // Sink stall mid-line.
    send(1, "HELLO", 1'b1);
    model_flush();
    wait_grant(4'b0010, "t4_grant", a);
    @(negedge clk);
    @(negedge clk);
    stall_until = cyc + 6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_tx_dv", tx_dv, 1);
      check("t4_stall_req_dr", req_dr, 0);
    end
    wait_idle("t4_idle");

    // Idle timeout releases requester 1; requester 2 is waiting.
    send(1, "A", 1'b0);
    model_flush();
    wait_req(1, 1'b1, "t5_xfer", a);
    send(2, "Z", 1'b1);
    model_flush();
    wait_grant(4'b0000, "t5_release", b);
    check("t5_timeout_cycles", b - (a + 1), Timeout);
    wait_grant(4'b0100, "t5_grant2", c);
    check("t5_next_grant", c - b, 1);
    wait_idle("t5_idle");

    // Reset while requester 3 is mid-line.
    send(3, "RESETLINE", 1'b1);
    model_flush();
    wait_grant(4'b1000, "t6_grant3", a);
    @(negedge clk);
    check("t6_pre_tx_dv", tx_dv, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_tx_dv", tx_dv, 0);
    check("t6_async_grant", grant, 0);
    check("t6_async_busy", busy, 0);
    for (int k = 0; k < NrReq; k++) begin
      src_q[k].delete();
      mdl_q[k].delete();
    end
    exp_q.delete();
    exp_g_q.delete();
    mdl_last = NrReq - 1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send(3, "Q", 1'b1);
    send(0, "P", 1'b1);
    model_flush();
    wait_grant(4'b0001, "t6_first_after_rst", a);
    wait_idle("t6_idle");

    // Randomized lines with random sink back-pressure.
    rand_dr = 1'b1;
    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      for (int k = 0; k < NrReq; k++)
        if ($urandom_range(0, 2) != 0) begin
          for (int l = $urandom_range(1, 3); l > 0; l--) begin
            for (int j = $urandom_range(0, 4); j > 0; j--)
              push_byte(k, 8'($urandom_range(8'h20, 8'h7E)));
            push_byte(k, Cr);
          end
        end
      model_flush();
      wait_idle("rand_idle");
    end
    rand_dr = 1'b0;

    check("sb_bytes_left", exp_q.size(), 0);
    check("sb_grants_left", exp_g_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
